// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: CBus request/response types plus the arbiter's shared typedefs.
package cbus_arbiter_pkg;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   localparam int CBUS_NUM_REQ = 2;
   localparam int CBUS_IDX_W   = $clog2(CBUS_NUM_REQ);

   typedef logic [CBUS_IDX_W-1:0] arb_idx_t;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/cbus_arb_picker.sv
// cbus_arb_picker: combinational winner selection; round-robin from last+1 when CBUS_ARB_RR_EN
// is defined, otherwise fixed priority with the lowest index winning.
module cbus_arb_picker
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = CBUS_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
`ifdef CBUS_ARB_RR_EN
   input  logic [IDX_W-1:0]   i_last,
`endif
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   // Scanning from the least preferred candidate lets the most preferred valid one win.
   always_comb begin
      o_idx = '0;
`ifdef CBUS_ARB_RR_EN
      for (int k = NUM_REQ; k >= 1; k--)
         if (i_valid[(int'(i_last) + k) % NUM_REQ]) o_idx = IDX_W'((int'(i_last) + k) % NUM_REQ);
`else
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (i_valid[k]) o_idx = IDX_W'(k);
`endif
   end

   assign o_any = |i_valid;

endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one CBus master port among NUM_REQ requesters, holding each grant
// until the last beat handshakes. Define CBUS_ARB_RR_EN for round-robin arbitration.
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = CBUS_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  cbus_req_t  [NUM_REQ-1:0]  ireqs,
   output cbus_resp_t [NUM_REQ-1:0]  iresps,
   output cbus_req_t                 oreq,
   input  cbus_resp_t                oresp
);

   arb_state_t         r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_sel, w_sel_nxt, w_win;
   logic [NUM_REQ-1:0] w_valid;
   logic               w_any, w_grant, w_release;

   always_comb begin
      w_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) w_valid[i] = ireqs[i].valid;
   end

   assign w_grant   = (r_state == ARB_IDLE) && w_any;
   assign w_release = (r_state == ARB_BUSY) && oresp.ready && oresp.last;

`ifdef CBUS_ARB_RR_EN
   logic [IDX_W-1:0] r_last;

   always_ff @(posedge clk) begin
      if (reset) r_last <= '0;
      else if (w_release) r_last <= r_sel;
   end

   cbus_arb_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .i_valid (w_valid),
      .i_last  (r_last),
      .o_idx   (w_win),
      .o_any   (w_any)
   );
`else
   cbus_arb_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .i_valid (w_valid),
      .o_idx   (w_win),
      .o_any   (w_any)
   );
`endif

   always_comb begin
      w_state_nxt = w_grant ? ARB_BUSY : w_release ? ARB_IDLE : r_state;
      w_sel_nxt   = w_grant ? w_win : r_sel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ARB_IDLE;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   // Outputs depend only on registered state and requester inputs, never oresp -> oreq.
   always_comb begin
      oreq   = '0;
      iresps = '0;
      if (r_state == ARB_BUSY) begin
         oreq          = ireqs[r_sel];
         iresps[r_sel] = oresp;
      end
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed vector table, random traffic against a transaction-level owner
// model, and a repeated-contention grant sequence.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   localparam logic [31:0] A0 = 32'h8000_0000;
   localparam logic [31:0] A1 = 32'h1fc0_0000;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   cbus_req_t [1:0]  ireqs;
   cbus_resp_t [1:0] iresps;
   cbus_req_t       oreq;
   cbus_resp_t      oresp;

   int n_tests = 0;
   int n_fail  = 0;
   int owner   = -1;
   int last_g  = 0;

   typedef struct {
      logic [4:0]  ctl;
      logic [31:0] rd;
      logic        ov;
      logic [31:0] addr;
      logic [1:0]  erdy;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   cbus_arbiter #(.NUM_REQ(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   function automatic vec_t mk(logic [4:0] ctl, logic [31:0] rd, logic ov, logic [31:0] addr,
                               logic [1:0] erdy, logic [31:0] ed);
      vec_t v;
      v.ctl = ctl; v.rd = rd; v.ov = ov; v.addr = addr; v.erdy = erdy; v.ed = ed;
      return v;
   endfunction

   function automatic int pick(logic [1:0] v, int last);
      int w = -1;
`ifdef CBUS_ARB_RR_EN
      for (int k = 1; k <= 2; k++) if (w < 0 && v[(last + k) % 2]) w = (last + k) % 2;
`else
      for (int k = 0; k < 2; k++) if (w < 0 && v[k]) w = k;
`endif
      return w;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic [4:0] ctl, logic [31:0] rd);
      reset          = ctl[4];
      ireqs[0].valid = ctl[3];
      ireqs[1].valid = ctl[2];
      oresp.ready    = ctl[1];
      oresp.last     = ctl[0];
      oresp.data     = rd;
   endtask

   task automatic sample();
      cbus_req_t       e_req;
      cbus_resp_t [1:0] e_rsp;
      @(negedge clk);
      e_req = '0;
      e_rsp = '0;
      if (owner >= 0) begin
         e_req        = ireqs[owner];
         e_rsp[owner] = oresp;
      end
      chk("model oreq", 128'(oreq), 128'(e_req));
      chk("model iresps", 128'(iresps), 128'(e_rsp));
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) begin
         owner  = -1;
         last_g = 0;
      end else if (owner < 0) owner = pick({ireqs[1].valid, ireqs[0].valid}, last_g);
      else if (oresp.ready && oresp.last) begin
         last_g = owner;
         owner  = -1;
      end
      #1;
   endtask

   task automatic fixed_reqs();
      ireqs          = '0;
      ireqs[0].addr  = A0;
      ireqs[0].len   = 4'd3;
      ireqs[0].size  = 3'd2;
      ireqs[1].addr  = A1;
      ireqs[1].size  = 3'd2;
   endtask

   initial begin
      int got, exp_g;
      fixed_reqs();
      oresp = '0;
      // {rst, v0, v1, ready, last}
      tbl.push_back(mk(5'b11000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b11000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b11000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01000, 32'h0, 1'b1, A0,    2'b00, 32'h0));
      tbl.push_back(mk(5'b01011, 32'h11, 1'b1, A0,   2'b01, 32'h11));
      tbl.push_back(mk(5'b00100, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b00100, 32'h0, 1'b1, A1,    2'b00, 32'h0));
      tbl.push_back(mk(5'b00100, 32'h0, 1'b1, A1,    2'b00, 32'h0));
      tbl.push_back(mk(5'b00111, 32'hdeadbeef, 1'b1, A1, 2'b10, 32'hdeadbeef));
      tbl.push_back(mk(5'b00000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01100, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01111, 32'h22, 1'b1, A0,   2'b01, 32'h22));
      tbl.push_back(mk(5'b00100, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b00111, 32'h33, 1'b1, A1,   2'b10, 32'h33));
      tbl.push_back(mk(5'b00000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01100, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01100, 32'h0, 1'b1, A0,    2'b00, 32'h0));
      tbl.push_back(mk(5'b01110, 32'h1, 1'b1, A0,    2'b01, 32'h1));
      tbl.push_back(mk(5'b01100, 32'h0, 1'b1, A0,    2'b00, 32'h0));
      tbl.push_back(mk(5'b01110, 32'h2, 1'b1, A0,    2'b01, 32'h2));
      tbl.push_back(mk(5'b01100, 32'h0, 1'b1, A0,    2'b00, 32'h0));
      tbl.push_back(mk(5'b01110, 32'h3, 1'b1, A0,    2'b01, 32'h3));
      tbl.push_back(mk(5'b01100, 32'h0, 1'b1, A0,    2'b00, 32'h0));
      tbl.push_back(mk(5'b01111, 32'h4, 1'b1, A0,    2'b01, 32'h4));
      tbl.push_back(mk(5'b00100, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b00100, 32'h0, 1'b1, A1,    2'b00, 32'h0));
      tbl.push_back(mk(5'b00111, 32'h5, 1'b1, A1,    2'b10, 32'h5));
      tbl.push_back(mk(5'b01000, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b01010, 32'h6, 1'b1, A0,    2'b01, 32'h6));
      tbl.push_back(mk(5'b01010, 32'h7, 1'b1, A0,    2'b01, 32'h7));
      tbl.push_back(mk(5'b11000, 32'h0, 1'b1, A0,    2'b00, 32'h0));
      tbl.push_back(mk(5'b00010, 32'h9, 1'b0, 32'h0, 2'b00, 32'h0));
      tbl.push_back(mk(5'b00011, 32'ha, 1'b0, 32'h0, 2'b00, 32'h0));

      drive(5'b11000, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].ctl, tbl[i].rd);
         sample();
         chk($sformatf("row%0d oreq.valid", i), 128'(oreq.valid), 128'(tbl[i].ov));
         chk($sformatf("row%0d oreq.addr", i), 128'(oreq.addr), 128'(tbl[i].addr));
         chk($sformatf("row%0d ready", i), 128'({iresps[1].ready, iresps[0].ready}), 128'(tbl[i].erdy));
         chk($sformatf("row%0d rdata", i), 128'(iresps[0].data | iresps[1].data), 128'(tbl[i].ed));
         advance();
      end

      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(63) == 0);
         for (int r = 0; r < 2; r++) begin
            ireqs[r].valid    = 1'($urandom_range(1));
            ireqs[r].is_write = 1'($urandom_range(1));
            ireqs[r].size     = 3'($urandom_range(7));
            ireqs[r].addr     = $urandom;
            ireqs[r].strobe   = 4'($urandom_range(15));
            ireqs[r].data     = $urandom;
            ireqs[r].len      = 4'($urandom_range(15));
         end
         oresp.ready = 1'($urandom_range(1));
         oresp.last  = 1'($urandom_range(1));
         oresp.data  = $urandom;
         sample();
         advance();
      end

      fixed_reqs();
      drive(5'b10000, 32'h0);
      sample();
      advance();
      drive(5'b01111, 32'h5a);
      got = 0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         sample();
         if (oreq.valid) begin
`ifdef CBUS_ARB_RR_EN
            exp_g = (got + 1) % 2;
`else
            exp_g = 0;
`endif
            chk($sformatf("grant%0d", got), 128'((oreq.addr == A1) ? 1 : 0), 128'(exp_g));
            got++;
         end
         advance();
      end
      chk("grant count", 128'(got), 128'(10));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
